serial_frame_tx: RTL

//  Upstream feeder for the 4-bit serial-serial shift register stage. Accepts a parallel

---
 rtl/serial_frame_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial feeder for a 4-bit serial shift register stage.
// Accepts a word over Valid/Ready, shifts it out one bit per DIV clocks with a
// one-clock Ser_Ena strobe per bit, pulses Done after the last strobe, then holds
// off for GAP bit periods before accepting the next word.
// Optional feature macro: PARITY_EN appends an even-parity bit after the data bits.
module serial_frame_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int GAP   = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Par_In,
  input  logic             Msb_First,
  input  logic             Valid,
  output logic             Ready,
  output logic             Ser_Out,
  output logic             Ser_Ena,
  output logic             Ser_LeRi,
  output logic             Busy,
  output logic             Done
);

`ifdef PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int GAPCLKS = GAP * DIV;
  localparam int DCW     = $clog2(DIV) + 1;
  localparam int BCW     = $clog2(NBITS) + 1;
  localparam int GCW     = $clog2(GAPCLKS + 1) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAPS
  } state_t;

  state_t           state_q;
  logic [NBITS-1:0] shift_q;
  logic [DCW-1:0]   divCnt_q;
  logic [BCW-1:0]   bitCnt_q;
  logic [GCW-1:0]   gapCnt_q;
  logic             doneArm_q;
  logic             ready_q;
  logic             serOut_q;
  logic             serEna_q;
  logic             leRi_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] ordered_d;
  logic [NBITS-1:0] load_d;

  // Arrange the incoming word so the first bit to send sits at the top of the shift register.
  always_comb begin
    ordered_d = Par_In;
    if (!Msb_First) begin
      for (int i = 0; i < WIDTH; i++) begin
        ordered_d[i] = Par_In[WIDTH-1-i];
      end
    end
`ifdef PARITY_EN
    load_d = {ordered_d, ^Par_In};
`else
    load_d = ordered_d;
`endif
  end

  // Framing FSM: every output is a register so downstream sees glitch-free strobes.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      divCnt_q  <= '0;
      bitCnt_q  <= '0;
      gapCnt_q  <= '0;
      doneArm_q <= 1'b0;
      ready_q   <= 1'b0;
      serOut_q  <= 1'b0;
      serEna_q  <= 1'b0;
      leRi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      serEna_q  <= 1'b0;
      doneArm_q <= 1'b0;
      done_q    <= doneArm_q;
      case (state_q)
        IDLE: begin
          serOut_q <= 1'b0;
          if (Valid && ready_q) begin
            shift_q  <= load_d;
            leRi_q   <= Msb_First;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            divCnt_q <= '0;
            bitCnt_q <= '0;
            state_q  <= SHIFT;
          end else begin
            ready_q <= 1'b1;
          end
        end
        SHIFT: begin
          serOut_q <= shift_q[NBITS-1];
          if (divCnt_q == DCW'(DIV - 1)) begin
            serEna_q <= 1'b1;
            divCnt_q <= '0;
            shift_q  <= shift_q << 1;
            bitCnt_q <= bitCnt_q + BCW'(1);
            if (bitCnt_q == BCW'(NBITS - 1)) begin
              doneArm_q <= 1'b1;
              if (GAP == 0) begin
                state_q <= IDLE;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                gapCnt_q <= '0;
                state_q  <= GAPS;
              end
            end
          end else begin
            divCnt_q <= divCnt_q + DCW'(1);
          end
        end
        GAPS: begin
          serOut_q <= 1'b0;
          if (gapCnt_q == GCW'(GAPCLKS)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            gapCnt_q <= gapCnt_q + GCW'(1);
          end
        end
        default: begin
          serOut_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign Ready    = ready_q;
  assign Ser_Out  = serOut_q;
  assign Ser_Ena  = serEna_q;
  assign Ser_LeRi = leRi_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule
